// File: rtl/xnor_pop_pkg.sv
// +----------------------------------------------------------------------------+
// | xnor_pop_pkg: shared constants, sizing helpers and beat tag type for the   |
// | XNOR-popcount engine.                                                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package xnor_pop_pkg;

  localparam int LEAF_W = 32;

  function automatic int pop_w(input int width);
    return $clog2(width + 1);
  endfunction

  // Number of pipeline registers placed after tree level lvl; stage s lands on level floor(s*levels/pipe).
  function automatic int regs_at_level(input int lvl, input int levels, input int pipe);
    int n;
    n = 0;
    for (int s = 1; s <= pipe; s++) begin
      if ((s * levels) / pipe == lvl) n++;
    end
    return n;
  endfunction

  typedef struct packed {
    logic first;
    logic last;
    logic valid;
  } beat_tag_t;

endpackage

`default_nettype wire

// File: rtl/xnor_pop_leaf.sv
// +----------------------------------------------------------------------------+
// | xnor_pop_leaf: combinational 32-bit XNOR followed by a 6-bit popcount.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module xnor_pop_leaf
  import xnor_pop_pkg::*;
(
  input  logic [LEAF_W-1:0] xi,
  input  logic [LEAF_W-1:0] wi,
  output logic [5:0]        pop
);

  logic [LEAF_W-1:0] w_match;

  assign w_match = ~(xi ^ wi);

  always_comb begin
    pop = '0;
    for (int i = 0; i < LEAF_W; i++) begin
      pop = pop + {5'd0, w_match[i]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/xnor_popcount_accum.sv
// +----------------------------------------------------------------------------+
// | xnor_popcount_accum: pipelined XNOR-popcount tree with group accumulator   |
// | and valid/ready result. Optional threshold output under XNOR_POP_THRESH_EN.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module xnor_popcount_accum
  import xnor_pop_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int PIPE  = 2,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [WIDTH-1:0] xi,
  input  logic [WIDTH-1:0] wi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_beats,
`ifdef XNOR_POP_THRESH_EN
  input  logic [ACC_W-1:0] thresh,
  output logic             out_bit,
`endif
  output logic             out_ovf
);

  localparam int POP_W  = pop_w(WIDTH);
  localparam int N_LEAF = WIDTH / LEAF_W;
  localparam int LEVELS = (N_LEAF > 1) ? $clog2(N_LEAF) : 0;
  localparam int N_PAD  = 1 << LEVELS;

  logic             w_adv;
  logic [POP_W-1:0] w_pop;
  beat_tag_t        w_tag_in;
  beat_tag_t        w_tag;

  logic             r_out_valid;
  logic             r_open;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  // One advance enable for the whole pipe: everything freezes while a result waits.
  assign w_adv     = !r_out_valid || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_out_valid;
  assign w_tag_in  = '{first: in_first, last: in_last, valid: in_valid};

  for (genvar b = 0; b <= LEVELS; b++) begin : g_lvl
    localparam int N    = N_PAD >> b;
    localparam int NREG = regs_at_level(b, LEVELS, PIPE);
    logic [N*POP_W-1:0] w_in;
    logic [N*POP_W-1:0] w_out;

    if (b == 0) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_slot
        if (i < N_LEAF) begin : g_used
          logic [5:0] w_leaf_pop;
          xnor_pop_leaf u_leaf (
            .xi  (xi[i*LEAF_W +: LEAF_W]),
            .wi  (wi[i*LEAF_W +: LEAF_W]),
            .pop (w_leaf_pop)
          );
          assign w_in[i*POP_W +: POP_W] = POP_W'(w_leaf_pop);
        end else begin : g_pad
          assign w_in[i*POP_W +: POP_W] = '0;
        end
      end
    end else begin : g_add
      for (genvar i = 0; i < N; i++) begin : g_slot
        assign w_in[i*POP_W +: POP_W] = g_lvl[b-1].w_out[(2*i)*POP_W +: POP_W]
                                      + g_lvl[b-1].w_out[(2*i+1)*POP_W +: POP_W];
      end
    end

    if (NREG == 0) begin : g_wire
      assign w_out = w_in;
    end else begin : g_reg
      logic [N*POP_W-1:0] r_stage [NREG];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < NREG; k++) r_stage[k] <= '0;
        end else if (w_adv) begin
          r_stage[0] <= w_in;
          for (int k = 1; k < NREG; k++) r_stage[k] <= r_stage[k-1];
        end
      end
      assign w_out = r_stage[NREG-1];
    end
  end

  assign w_pop = g_lvl[LEVELS].w_out;

  // Tags run in a plain PIPE-deep shift so they line up with the tree output.
  if (PIPE == 0) begin : g_tag_wire
    assign w_tag = w_tag_in;
  end else begin : g_tag_pipe
    beat_tag_t r_tag [PIPE];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < PIPE; k++) r_tag[k] <= '0;
      end else if (w_adv) begin
        r_tag[0] <= w_tag_in;
        for (int k = 1; k < PIPE; k++) r_tag[k] <= r_tag[k-1];
      end
    end
    assign w_tag = r_tag[PIPE-1];
  end

  logic             w_beat;
  logic             w_start;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_acc_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_ovf_next;

  // A stray non-first beat with no open group starts a fresh group from zero.
  always_comb begin
    w_beat     = w_adv && w_tag.valid;
    w_start    = w_tag.first || !r_open;
    w_sum      = {1'b0, r_acc} + (ACC_W+1)'(w_pop);
    w_acc_next = ACC_W'(w_pop);
    w_cnt_next = CNT_W'(1);
    w_ovf_next = 1'b0;
    if (!w_start) begin
      w_acc_next = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
      w_ovf_next = r_ovf | w_sum[ACC_W];
      w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_open      <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      out_sum     <= '0;
      out_beats   <= '0;
      out_ovf     <= 1'b0;
`ifdef XNOR_POP_THRESH_EN
      out_bit     <= 1'b0;
`endif
    end else begin
      if (w_adv) r_out_valid <= w_beat && w_tag.last;
      if (w_beat) begin
        r_acc <= w_acc_next;
        r_cnt <= w_cnt_next;
        r_ovf <= w_ovf_next;
        if (w_tag.last) begin
          r_open    <= 1'b0;
          out_sum   <= w_acc_next;
          out_beats <= w_cnt_next;
          out_ovf   <= w_ovf_next;
`ifdef XNOR_POP_THRESH_EN
          out_bit   <= (w_acc_next >= thresh);
`endif
        end else begin
          r_open <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire
